dffram_ctrl: RTL and testbench
==============================

DFFRAM_CTRL -- requirements
Module: dffram_ctrl

Interface
REQ-001 SHALL have parameters: Depth, default 4096, SRAM word count; AW, default 12, SRAM word-address width; DW, default 32, data width.
REQ-002 SHALL have port clk_i, input, 1, the single clock for all state.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have request ports: req_valid_i in 1; req_ready_o out 1; req_addr_i in 32, byte address; req_we_i in 1; req_be_i in 4; req_wdata_i in 32.
REQ-005 SHALL have response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_rdata_o out 32; rsp_err_o out 1.
REQ-006 SHALL have SRAM ports: ram_en_o out 1; ram_we_o out 4, byte write mask; ram_di_o out 32; ram_a_o out AW, word address; ram_do_i in 32, read data valid one cycle after ram_en_o.

Function
REQ-007 SHALL accept a request in a cycle where req_valid_i and req_ready_o are both high; the request fields are sampled in that cycle.
REQ-008 SHALL flag an accepted request as an error when req_addr_i[1:0] != 0 or req_addr_i[31:AW+2] != 0.
REQ-009 SHALL, for an accepted non-error request, drive combinationally in the accept cycle: ram_en_o=1, ram_a_o=req_addr_i[AW+1:2], ram_di_o=req_wdata_i, ram_we_o=req_be_i when req_we_i=1, else 0.
REQ-010 SHALL hold ram_en_o=0 and ram_we_o=0 in every cycle without a non-error accept, including error accepts.
REQ-011 SHALL keep a one-deep in-flight register: {valid, we, err}, set on every accept and cleared otherwise.
REQ-012 SHALL, in the cycle after an accept, push {rdata, err} into a 2-entry response FIFO: rdata=ram_do_i for a non-error read, else 0; err=in-flight err.
REQ-013 SHALL present the FIFO head on rsp_valid_o, rsp_rdata_o and rsp_err_o, with no fall-through; accept-to-rsp_valid_o latency is exactly 2 cycles when the FIFO is empty.
REQ-014 SHALL pop the FIFO on rsp_valid_o && rsp_ready_i; rsp_* outputs hold stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-015 SHALL compute req_ready_o = (fifo_count + inflight_valid - pop) < 2; this combinational path from rsp_ready_i is intentional and sustains 1 request/cycle when rsp_ready_i is held high.
REQ-016 SHALL never overflow or underflow the FIFO; push and pop in the same cycle leave the count unchanged.
REQ-017 SHALL return responses strictly in request order, one response per accepted request, writes included.
REQ-018 SHALL treat req_we_i=1 with req_be_i=0 as a write: SRAM accessed with ram_we_o=0, response rdata=0, err=0.

Reset
REQ-019 SHALL, on rst_ni low, asynchronously clear the in-flight register, FIFO pointers and count; this discards any pending SRAM read.
REQ-020 SHALL drive these values while in reset: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, ram_en_o=0, ram_we_o=0.
REQ-021 SHALL raise req_ready_o in the first cycle after rst_ni deasserts.

Structure
REQ-022 SHALL take AW, DW and the response entry typedef {rdata[DW-1:0], err} from shared package dffram_pkg.
REQ-023 SHALL implement the response FIFO as sub-module dffram_rsp_fifo: depth 2, push/pop/full/empty/count.

Verification
REQ-024 Read: preload word 5=32'hDEADBEEF; read addr 32'h14 with rsp_ready_i=1 -> rsp_valid_o 2 cycles after accept, rdata=32'hDEADBEEF, err=0.
REQ-025 Byte write: word 3=0; write addr 32'h0C, be=4'b0101, wdata=32'hAABBCCDD -> ram_we_o=4'b0101 in accept cycle; readback=32'h00BB00DD.
REQ-026 Errors: read addr 32'h2 and 32'h4000 -> ram_en_o stays 0; two responses with err=1, rdata=0.
REQ-027 Backpressure: 4 back-to-back reads with rsp_ready_i=0 -> req_ready_o falls after 2 accepts; release -> all 4 responses returned in order with correct data.
REQ-028 Streaming: 16 consecutive reads with rsp_ready_i=1 -> one accept per cycle, 16 in-order responses, no bubbles.
REQ-029 Reset mid-flight: assert rst_ni with one request in flight and one FIFO entry -> rsp_valid_o=0 immediately; no stale response after release.

Source files
------------

// File: rtl/dffram_pkg.sv
// Shared widths and types for the DFFRAM controller and its response FIFO.
package dffram_pkg;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;
   localparam int unsigned RspDepth = 2;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_entry_t;

   typedef struct packed {
      logic valid;
      logic we;
      logic err;
   } inflight_t;

   // Entries the response path will hold once this cycle's in-flight push and pop have settled.
   function automatic logic [2:0] next_occupancy(input logic [1:0] count, input logic inflight,
                                                 input logic pop);
      return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/dffram_rsp_fifo.sv
// Two-entry response FIFO; the head is always a registered entry, so nothing falls through.
module dffram_rsp_fifo
   import dffram_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push,
   input  rsp_entry_t push_data,
   input  logic       pop,
   output rsp_entry_t head,
   output logic       full,
   output logic       empty,
   output logic [1:0] count
);

   rsp_entry_t entries [RspDepth];
   logic       wr_ptr;
   logic       rd_ptr;
   logic       do_push;
   logic       do_pop;

   assign full    = (count == 2'(RspDepth));
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = entries[rd_ptr];

   // Storage is cleared too, so the head reads as zero while in reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < RspDepth; i++) begin
            entries[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            entries[wr_ptr] <= push_data;
            wr_ptr          <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dffram_ctrl.sv
// DFFRAM controller: valid/ready word requests, one-cycle SRAM access, in-order responses
// through a two-entry FIFO.
module dffram_ctrl #(
   parameter int unsigned Depth = 4096,
   parameter int unsigned AW    = dffram_pkg::AW,
   parameter int unsigned DW    = dffram_pkg::DW
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic [31:0]   req_addr_i,
   input  logic          req_we_i,
   input  logic [3:0]    req_be_i,
   input  logic [DW-1:0] req_wdata_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          rsp_err_o,
   output logic          ram_en_o,
   output logic [3:0]    ram_we_o,
   output logic [DW-1:0] ram_di_o,
   output logic [AW-1:0] ram_a_o,
   input  logic [DW-1:0] ram_do_i
);
   import dffram_pkg::*;

   logic          addr_err;
   logic          accept;
   logic          pop;
   inflight_t     inflight;
   rsp_entry_t    push_data;
   rsp_entry_t    head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [1:0]    fifo_count;

   assign addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:AW+2] != '0);
   assign accept   = req_valid_i && req_ready_o;

   // Error accepts still take a response slot but never touch the SRAM.
   assign ram_en_o = accept && !addr_err;
   assign ram_we_o = (ram_en_o && req_we_i) ? req_be_i : 4'b0000;
   assign ram_a_o  = req_addr_i[AW+1:2];
   assign ram_di_o = req_wdata_i;

   // One-deep record of last cycle's accept, lining up with the SRAM read data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight <= '0;
      end else begin
         inflight.valid <= accept;
         inflight.we    <= accept && req_we_i;
         inflight.err   <= accept && addr_err;
      end
   end

   assign push_data.rdata = (inflight.we || inflight.err) ? '0 : ram_do_i;
   assign push_data.err   = inflight.err;

   dffram_rsp_fifo u_rsp_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (inflight.valid),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign rsp_valid_o = !fifo_empty;
   assign rsp_rdata_o = head.rdata;
   assign rsp_err_o   = head.err;
   assign pop         = rsp_valid_o && rsp_ready_i;

   // rsp_ready_i feeds req_ready_o directly so a slot freed this cycle is reusable at once.
   assign req_ready_o = rst_ni && (next_occupancy(fifo_count, inflight.valid, pop) < 3'd2);

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(inflight.valid && fifo_full && !pop));

   a_addr_in_depth: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ram_en_o |-> (32'(ram_a_o) < Depth));

endmodule

// File: tb/tb_dffram_ctrl.sv
// Randomized scoreboard bench for dffram_ctrl against a word-level memory reference model.
module tb_dffram_ctrl;

   localparam int RspAlways = 0;
   localparam int RspHold   = 1;
   localparam int RspRandom = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc_cyc;
      bit          chk_lat;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        req_we_i;
   logic [3:0]  req_be_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        ram_en_o;
   logic [3:0]  ram_we_o;
   logic [31:0] ram_di_o;
   logic [11:0] ram_a_o;
   logic [31:0] ram_do_i;

   logic [31:0] sram [0:4095];
   logic [31:0] ref_mem [0:4095];
   exp_t        exp_q [$];
   int          cyc = 0;
   int          mode = RspAlways;
   int          n_compared = 0;
   int          n_mismatched = 0;
   int          rsp_pops = 0;

   dffram_ctrl dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_we_i    (req_we_i),
      .req_be_i    (req_be_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .ram_en_o    (ram_en_o),
      .ram_we_o    (ram_we_o),
      .ram_di_o    (ram_di_o),
      .ram_a_o     (ram_a_o),
      .ram_do_i    (ram_do_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Synchronous SRAM with byte enables; read data appears the cycle after the enable.
   always @(posedge clk_i) begin
      if (ram_en_o) begin
         ram_do_i <= sram[ram_a_o];
         for (int b = 0; b < 4; b++) begin
            if (ram_we_o[b]) sram[ram_a_o][8*b +: 8] <= ram_di_o[8*b +: 8];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drives one request until accepted; on accept, predicts the response from the reference memory.
   task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                input logic [31:0] wdata, input bit chk_lat, input int max_wait,
                                output int waited);
      exp_t        e;
      logic        err;
      logic [11:0] word;
      waited = 0;
      forever begin
         @(negedge clk_i);
         req_valid_i = 1'b1;
         req_addr_i  = addr;
         req_we_i    = we;
         req_be_i    = be;
         req_wdata_i = wdata;
         #2;
         if (req_ready_o) break;
         waited++;
         if (waited > max_wait) begin
            checkOutput("req_accept_timeout", 32'(req_ready_o), 32'd1);
            req_valid_i = 1'b0;
            return;
         end
      end
      err  = (addr[1:0] != 2'b00) || (addr[31:14] != 18'd0);
      word = addr[13:2];
      checkOutput("ram_en", 32'(ram_en_o), 32'(!err));
      checkOutput("ram_we", 32'(ram_we_o), (!err && we) ? 32'(be) : 32'd0);
      if (!err) begin
         checkOutput("ram_a", 32'(ram_a_o), 32'(word));
         checkOutput("ram_di", ram_di_o, wdata);
      end
      e.err     = err;
      e.acc_cyc = cyc;
      e.chk_lat = chk_lat;
      e.rdata   = (err || we) ? 32'd0 : ref_mem[word];
      if (!err && we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[word][8*b +: 8] = wdata[8*b +: 8];
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(negedge clk_i);
         req_valid_i = 1'b0;
      end
   endtask

   task automatic waitDrain(input int budget);
      int t = 0;
      idleCycles(1);
      while (exp_q.size() != 0 && t < budget) begin
         idleCycles(1);
         t++;
      end
      checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: drives rsp_ready_i and checks every presented response against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         case (mode)
            RspAlways: rsp_ready_i = 1'b1;
            RspHold:   rsp_ready_i = 1'b0;
            default:   rsp_ready_i = 1'($urandom_range(0, 1));
         endcase
         #3;
         if (rst_ni && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
               e = exp_q[0];
               checkOutput("rsp_rdata", rsp_rdata_o, e.rdata);
               checkOutput("rsp_err", 32'(rsp_err_o), 32'(e.err));
               if (e.chk_lat) checkOutput("rsp_latency", 32'(cyc - e.acc_cyc), 32'd2);
               if (rsp_ready_i) begin
                  void'(exp_q.pop_front());
                  rsp_pops++;
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          waited;
      int          pops_before;
      logic [31:0] addr;
      logic [31:0] v;
      int          w;
      int          r;

      rst_ni      = 1'b0;
      req_valid_i = 1'b1;
      req_addr_i  = 32'h14;
      req_we_i    = 1'b1;
      req_be_i    = 4'hF;
      req_wdata_i = 32'h1234_5678;
      rsp_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      checkOutput("reset_req_ready", 32'(req_ready_o), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata_o, 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err_o), 32'd0);
      checkOutput("reset_ram_en", 32'(ram_en_o), 32'd0);
      checkOutput("reset_ram_we", 32'(ram_we_o), 32'd0);

      @(negedge clk_i);
      req_valid_i = 1'b0;
      rst_ni      = 1'b1;
      #1;
      checkOutput("ready_after_reset", 32'(req_ready_o), 32'd1);

      // Fill the working set with full-word writes; word 5 and word 3 get their directed values.
      for (int i = 0; i < 32; i++) begin
         v = (i == 5) ? 32'hDEADBEEF : (i == 3) ? 32'd0 : $urandom;
         applyStimulus(32'(i * 4), 1'b1, 4'hF, v, 1'b0, 20, waited);
      end
      waitDrain(100);

      applyStimulus(32'h14, 1'b0, 4'h0, 32'd0, 1'b1, 5, waited);
      waitDrain(20);

      applyStimulus(32'h0C, 1'b1, 4'b0101, 32'hAABBCCDD, 1'b0, 5, waited);
      applyStimulus(32'h0C, 1'b0, 4'h0, 32'd0, 1'b1, 5, waited);
      applyStimulus(32'h10, 1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b0, 5, waited);
      waitDrain(20);

      applyStimulus(32'h2, 1'b0, 4'h0, 32'd0, 1'b0, 5, waited);
      applyStimulus(32'h4000, 1'b0, 4'h0, 32'd0, 1'b0, 5, waited);
      waitDrain(20);

      // Backpressure: two accepts fill the path, the third request must stall until release.
      mode = RspHold;
      idleCycles(1);
      applyStimulus(32'h14, 1'b0, 4'h0, 32'd0, 1'b0, 5, waited);
      applyStimulus(32'h0C, 1'b0, 4'h0, 32'd0, 1'b0, 5, waited);
      repeat (3) begin
         @(negedge clk_i);
         req_valid_i = 1'b1;
         req_addr_i  = 32'h8;
         req_we_i    = 1'b0;
         #2;
         checkOutput("bp_ready_low", 32'(req_ready_o), 32'd0);
      end
      mode = RspAlways;
      applyStimulus(32'h8, 1'b0, 4'h0, 32'd0, 1'b0, 10, waited);
      applyStimulus(32'h1C, 1'b0, 4'h0, 32'd0, 1'b0, 10, waited);
      waitDrain(50);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(32'($urandom_range(0, 31) * 4), 1'b0, 4'h0, 32'd0, 1'b1, 16, waited);
         checkOutput("stream_stall", 32'(waited), 32'd0);
      end
      waitDrain(50);

      // Reset with one response queued and one read still in flight.
      mode = RspHold;
      idleCycles(1);
      applyStimulus(32'h14, 1'b0, 4'h0, 32'd0, 1'b0, 5, waited);
      applyStimulus(32'h18, 1'b0, 4'h0, 32'd0, 1'b0, 5, waited);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      #1;
      checkOutput("pre_reset_rsp_valid", 32'(rsp_valid_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      checkOutput("midreset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("midreset_req_ready", 32'(req_ready_o), 32'd0);
      checkOutput("midreset_rsp_rdata", rsp_rdata_o, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      mode   = RspAlways;
      #1;
      checkOutput("ready_after_midreset", 32'(req_ready_o), 32'd1);
      pops_before = rsp_pops;
      idleCycles(6);
      checkOutput("no_stale_rsp", 32'(rsp_pops - pops_before), 32'd0);

      mode = RspRandom;
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         w = $urandom_range(0, 31);
         if (r == 0)      addr = 32'(w * 4) + 32'($urandom_range(1, 3));
         else if (r == 1) addr = (32'h4000 << $urandom_range(0, 17)) | 32'(w * 4);
         else             addr = 32'(w * 4);
         applyStimulus(addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                       1'b0, 40, waited);
         if ($urandom_range(0, 3) == 0) idleCycles(1);
      end
      mode = RspAlways;
      waitDrain(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
